// File: rtl/lcrc_chk_stream.sv
// lcrc_chk_stream: streaming LCRC checker for received DLL frames (seq + TLP + LCRC)
// Ports:
//   clk, rst (async, active-low)
//   in_vld/in_sop/in_eop/in_nbytes/in_data : beat stream, byte 0 in the MSBs, no backpressure
//   out_vld/out_good/out_bad/out_nullified/out_len_err/out_seq : one-cycle result strobe, 1 clk after eop
//   good_cnt/bad_cnt : saturating frame counters
module lcrc_chk_stream #(
    parameter int          DATA_W    = 128,
    parameter int          MIN_BYTES = 18,
    parameter int          MAX_BYTES = 4122,
    parameter logic [31:0] POLY      = 32'h04C11DB7,
    parameter int          CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_vld,
    input  logic                        in_sop,
    input  logic                        in_eop,
    input  logic [$clog2(DATA_W/8):0]   in_nbytes,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_vld,
    output logic                        out_good,
    output logic                        out_bad,
    output logic                        out_nullified,
    output logic                        out_len_err,
    output logic [11:0]                 out_seq,
    output logic [CNT_W-1:0]            good_cnt,
    output logic [CNT_W-1:0]            bad_cnt
);
    localparam int B  = DATA_W / 8;
    localparam int LW = $clog2(MAX_BYTES + 2);
    typedef enum logic [1:0] {IDLE, BODY, RESULT} state_t;
    state_t state, state_n;
    logic [31:0] crc_q, crc_n, hb_q, hb_n;
    logic [2:0] hbn_q, hbn_n;
    logic [LW-1:0] len_q, len_n;
    logic [11:0] seq_q, seq_n, r_seq;
    logic [B*8+31:0] win;
    logic abort, start, take, done;
    logic r_vld, r_good, r_bad, r_nul, r_len;
    int nb, hbn, sum, lenu;
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
        return r;
    endfunction
    // Window = {holdback, beat}; the last 4 valid bytes always sit at window bytes nb..nb+3,
    // so every valid byte before index nb is folded into the CRC.
    // A sop+eop beat arriving mid-frame only reports the aborted frame; the new one is dropped.
    always_comb begin
        abort   = state == BODY && in_vld && in_sop;
        start   = in_vld && in_sop && !(abort && in_eop);
        take    = start || (state == BODY && in_vld && !in_sop);
        done    = take && in_eop;
        nb      = in_eop ? int'(in_nbytes) : B;
        hbn     = start ? 0 : int'(hbn_q);
        win     = {start ? 32'h0 : hb_q, in_data};
        crc_n   = start ? 32'hFFFF_FFFF : crc_q;
        for (int j = 0; j < B; j++)
            if (j >= 4 - hbn && j < nb) crc_n = crc_byte(crc_n, win[(B+4-j)*8-1 -: 8]);
        hb_n    = win[(B+4-nb)*8-1 -: 32];
        hbn_n   = (hbn + nb >= 4) ? 3'd4 : 3'(hbn + nb);
        sum     = (start ? 0 : int'(len_q)) + nb;
        len_n   = (sum > MAX_BYTES) ? LW'(MAX_BYTES + 1) : LW'(sum);
        seq_n   = start ? {in_data[DATA_W-5 -: 4], in_data[DATA_W-9 -: 8]} : seq_q;
        lenu    = abort ? int'(len_q) : int'(len_n);
        r_vld   = done || abort;
        r_len   = r_vld && (abort || lenu < MIN_BYTES || lenu > MAX_BYTES);
        r_nul   = r_vld && !r_len && hb_n == ~crc_n;
        r_good  = r_vld && !r_len && hb_n == crc_n;
        r_bad   = r_vld && !r_good && !r_nul;
        r_seq   = (!r_vld || lenu < 6) ? 12'h0 : (abort ? seq_q : seq_n);
        state_n = take ? (in_eop ? RESULT : BODY) : (state == BODY && !in_vld) ? BODY : IDLE;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            crc_q         <= 32'hFFFF_FFFF;
            hb_q          <= '0;
            hbn_q         <= '0;
            len_q         <= '0;
            seq_q         <= '0;
            out_vld       <= 1'b0;
            out_good      <= 1'b0;
            out_bad       <= 1'b0;
            out_nullified <= 1'b0;
            out_len_err   <= 1'b0;
            out_seq       <= '0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
        end else begin
            if (take) begin
                crc_q <= crc_n;
                hb_q  <= hb_n;
                hbn_q <= hbn_n;
                len_q <= len_n;
                seq_q <= seq_n;
            end
            out_vld       <= r_vld;
            out_good      <= r_good;
            out_bad       <= r_bad;
            out_nullified <= r_nul;
            out_len_err   <= r_len;
            out_seq       <= r_seq;
            if (r_good && !(&good_cnt)) good_cnt <= good_cnt + CNT_W'(1);
            if (r_bad && !(&bad_cnt)) bad_cnt <= bad_cnt + CNT_W'(1);
        end
endmodule
